// File: rtl/bpf_stage1_scoreboard_pkg.sv
// rtl/bpf_stage1_scoreboard_pkg.sv - BPF opcode field codes and scoreboard entry layout
package bpf_stage1_scoreboard_pkg;

  localparam logic [2:0] CLS_LD   = 3'd0;
  localparam logic [2:0] CLS_LDX  = 3'd1;
  localparam logic [2:0] CLS_ST   = 3'd2;
  localparam logic [2:0] CLS_STX  = 3'd3;
  localparam logic [2:0] CLS_ALU  = 3'd4;
  localparam logic [2:0] CLS_JMP  = 3'd5;
  localparam logic [2:0] CLS_RET  = 3'd6;
  localparam logic [2:0] CLS_MISC = 3'd7;

  localparam logic [2:0] MODE_IND = 3'd2;
  localparam logic [2:0] MODE_MEM = 3'd3;

  localparam logic [1:0] RET_X = 2'd1;
  localparam logic [1:0] RET_A = 2'd2;

  typedef struct packed {
    logic ra;
    logic rx;
    logic rm;
    logic wa;
    logic wx;
    logic wm;
  } rw_set_t;

  typedef struct packed {
    logic       valid;
    logic       wa;
    logic       wx;
    logic       wm;
    logic [3:0] k;
  } sb_entry_t;

endpackage

// File: rtl/bpf_stage1_scoreboard_rw_set_decode.sv
// rtl/bpf_stage1_scoreboard_rw_set_decode.sv - opcode to register read/write set
module bpf_stage1_scoreboard_rw_set_decode
  import bpf_stage1_scoreboard_pkg::*;
(
  input  logic [7:0] opcode,
  output rw_set_t    rw
);

  logic [2:0] cls;
  logic [2:0] mode;
  logic [1:0] rsrc;
  logic       alu_or_jmp;

  assign cls        = opcode[2:0];
  assign mode       = opcode[7:5];
  assign rsrc       = opcode[4:3];
  assign alu_or_jmp = (cls == CLS_ALU) | (cls == CLS_JMP);

  // MISC bit 7 selects TXA (1) versus TAX (0)
  assign rw.ra = alu_or_jmp | (cls == CLS_ST) | ((cls == CLS_RET) & (rsrc == RET_A))
               | ((cls == CLS_MISC) & ~opcode[7]);
  assign rw.rx = (cls == CLS_STX) | ((cls == CLS_RET) & (rsrc == RET_X))
               | ((cls == CLS_MISC) & opcode[7]) | (alu_or_jmp & opcode[3])
               | ((cls == CLS_LD) & (mode == MODE_IND));
  assign rw.rm = ((cls == CLS_LD) | (cls == CLS_LDX)) & (mode == MODE_MEM);
  assign rw.wa = (cls == CLS_LD) | (cls == CLS_ALU) | ((cls == CLS_MISC) & opcode[7]);
  assign rw.wx = (cls == CLS_LDX) | ((cls == CLS_MISC) & ~opcode[7]);
  assign rw.wm = (cls == CLS_ST) | (cls == CLS_STX);

endmodule

// File: rtl/bpf_stage1_scoreboard.sv
// rtl/bpf_stage1_scoreboard.sv - stage-1 hazard controller with in-flight writer scoreboard
module bpf_stage1_scoreboard
  import bpf_stage1_scoreboard_pkg::*;
#(
  parameter int PIPE_DEPTH  = 2,
  parameter bit FWD_EN      = 1'b0,
  parameter bit MEM_TRACK   = 1'b1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [15:0]            in_opcode,
  input  logic [3:0]             in_k_lo,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_opcode,
  output logic                   out_A_en,
  output logic                   out_X_en,
  output logic                   out_mem_wr,
  output logic [STALL_CNT_W-1:0] stall_count
);

  // With forwarding the oldest slot's result is bypassed, so it is never compared
  localparam int CHK_SLOTS = FWD_EN ? PIPE_DEPTH - 1 : PIPE_DEPTH;

  sb_entry_t [PIPE_DEPTH-1:0] slot_q, slot_d;
  logic [15:0]                out_opcode_q, out_opcode_d;
  logic [STALL_CNT_W-1:0]     stall_q, stall_d;
  rw_set_t                    rw;
  logic                       hazard;
  logic                       accept;

  bpf_stage1_scoreboard_rw_set_decode u_rw_decode (
    .opcode (in_opcode[7:0]),
    .rw     (rw)
  );

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < CHK_SLOTS; i++) begin
      if (slot_q[i].valid &&
          ((rw.ra & slot_q[i].wa) || (rw.rx & slot_q[i].wx) ||
           (MEM_TRACK & rw.rm & slot_q[i].wm & (slot_q[i].k == in_k_lo)))) begin
        hazard = 1'b1;
      end
    end
  end

  assign in_ready = flush | (out_ready & ~hazard);
  assign accept   = in_valid & out_ready & ~hazard & ~flush;

  always_comb begin
    slot_d       = slot_q;
    out_opcode_d = out_opcode_q;
    stall_d      = stall_q;
    if (out_ready) begin
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        slot_d[i] = slot_q[i-1];
      end
      slot_d[0]    = '0;
      out_opcode_d = '0;
      if (accept) begin
        slot_d[0].valid = 1'b1;
        slot_d[0].wa    = rw.wa;
        slot_d[0].wx    = rw.wx;
        slot_d[0].wm    = rw.wm;
        slot_d[0].k     = in_k_lo;
        out_opcode_d    = in_opcode;
      end
    end
    if (in_valid && out_ready && hazard && !flush && !(&stall_q)) begin
      stall_d = stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q       <= '0;
      out_opcode_q <= '0;
      stall_q      <= '0;
    end else begin
      slot_q       <= slot_d;
      out_opcode_q <= out_opcode_d;
      stall_q      <= stall_d;
    end
  end

  assign out_valid   = slot_q[0].valid;
  assign out_A_en    = slot_q[0].wa;
  assign out_X_en    = slot_q[0].wx;
  assign out_mem_wr  = slot_q[0].wm;
  assign out_opcode  = out_opcode_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_bpf_stage1_scoreboard.sv
// tb/tb_bpf_stage1_scoreboard.sv - directed bench for the stage-1 scoreboard
module tb_bpf_stage1_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_opcode = 16'h0;
  logic [3:0]  in_k_lo = 4'h0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic        sel = 1'b0;

  logic        in_ready_d, out_valid_d, a_en_d, x_en_d, mem_wr_d;
  logic [15:0] out_opcode_d;
  logic [15:0] stall_count_d;
  logic        in_ready_f, out_valid_f, a_en_f, x_en_f, mem_wr_f;
  logic [15:0] out_opcode_f;
  logic [1:0]  stall_count_f;
  logic        rdy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rdy = sel ? in_ready_f : in_ready_d;

  bpf_stage1_scoreboard dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_opcode(in_opcode), .in_k_lo(in_k_lo),
    .in_ready(in_ready_d), .flush(flush), .out_valid(out_valid_d), .out_ready(out_ready),
    .out_opcode(out_opcode_d), .out_A_en(a_en_d), .out_X_en(x_en_d), .out_mem_wr(mem_wr_d),
    .stall_count(stall_count_d)
  );

  bpf_stage1_scoreboard #(.PIPE_DEPTH(2), .FWD_EN(1'b1), .MEM_TRACK(1'b0), .STALL_CNT_W(2)) dut_f (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_opcode(in_opcode), .in_k_lo(in_k_lo),
    .in_ready(in_ready_f), .flush(flush), .out_valid(out_valid_f), .out_ready(out_ready),
    .out_opcode(out_opcode_f), .out_A_en(a_en_f), .out_X_en(x_en_f), .out_mem_wr(mem_wr_f),
    .stall_count(stall_count_f)
  );

  task automatic do_reset(input logic s);
    @(negedge clk);
    sel = s; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [15:0] op, input logic [3:0] k, output int stalls);
    stalls = 0;
    @(negedge clk);
    in_valid = 1'b1; in_opcode = op; in_k_lo = k; out_ready = 1'b1; flush = 1'b0;
    #1;
    while (!rdy && stalls < 20) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid_d !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid_d); end
    checks++; if ({a_en_d, x_en_d, mem_wr_d} !== 3'b000) begin errors++; $display("FAIL reset_en: got %b want 000", {a_en_d, x_en_d, mem_wr_d}); end
    checks++; if (out_opcode_d !== 16'h0) begin errors++; $display("FAIL reset_opcode: got %h want 0000", out_opcode_d); end
    checks++; if (stall_count_d !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_count_d); end
    checks++; if (out_valid_f !== 1'b0 || stall_count_f !== 2'd0) begin errors++; $display("FAIL reset_fwd_inst: got valid=%0b stall=%0d want 0/0", out_valid_f, stall_count_f); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_raw_a;
    int s;
    do_reset(1'b0);
    send(16'h0000, 4'h0, s);
    checks++; if (s !== 0) begin errors++; $display("FAIL ld_stalls: got %0d want 0", s); end
    checks++; if (out_valid_d !== 1'b1 || a_en_d !== 1'b1) begin errors++; $display("FAIL ld_issue: got valid=%0b a_en=%0b want 1/1", out_valid_d, a_en_d); end
    send(16'h0004, 4'h0, s);
    checks++; if (s !== 2) begin errors++; $display("FAIL alu_stalls: got %0d want 2", s); end
    checks++; if (stall_count_d !== 16'd2) begin errors++; $display("FAIL alu_stall_count: got %0d want 2", stall_count_d); end
    checks++; if (out_valid_d !== 1'b1 || out_opcode_d !== 16'h0004) begin errors++; $display("FAIL alu_issue: got valid=%0b op=%h want 1/0004", out_valid_d, out_opcode_d); end
  endtask

  task automatic test_forwarding;
    int s;
    do_reset(1'b1);
    send(16'h0000, 4'h0, s);
    send(16'h0004, 4'h0, s);
    checks++; if (s !== 1) begin errors++; $display("FAIL fwd_stalls: got %0d want 1", s); end
    checks++; if (stall_count_f !== 2'd1) begin errors++; $display("FAIL fwd_stall_count: got %0d want 1", stall_count_f); end
  endtask

  task automatic test_mem;
    int s;
    do_reset(1'b0);
    send(16'h0002, 4'h3, s);
    checks++; if (mem_wr_d !== 1'b1 || a_en_d !== 1'b0) begin errors++; $display("FAIL st_issue: got mem_wr=%0b a_en=%0b want 1/0", mem_wr_d, a_en_d); end
    send(16'h0061, 4'h5, s);
    checks++; if (s !== 0) begin errors++; $display("FAIL ldx_other_k: got %0d want 0", s); end
    checks++; if (x_en_d !== 1'b1 || mem_wr_d !== 1'b0) begin errors++; $display("FAIL ldx_issue: got x_en=%0b mem_wr=%0b want 1/0", x_en_d, mem_wr_d); end
    do_reset(1'b0);
    send(16'h0002, 4'h3, s);
    send(16'h0061, 4'h3, s);
    checks++; if (s !== 2) begin errors++; $display("FAIL ldx_same_k: got %0d want 2", s); end
    do_reset(1'b1);
    send(16'h0002, 4'h3, s);
    send(16'h0061, 4'h3, s);
    checks++; if (s !== 0) begin errors++; $display("FAIL ldx_mem_untracked: got %0d want 0", s); end
  endtask

  task automatic test_tax_txa;
    int s;
    do_reset(1'b0);
    send(16'h0007, 4'h0, s);
    send(16'h0016, 4'h0, s);
    checks++; if (s !== 0) begin errors++; $display("FAIL tax_ret_a: got %0d want 0", s); end
    do_reset(1'b0);
    send(16'h0087, 4'h0, s);
    checks++; if (a_en_d !== 1'b1 || x_en_d !== 1'b0) begin errors++; $display("FAIL txa_issue: got a_en=%0b x_en=%0b want 1/0", a_en_d, x_en_d); end
    send(16'h0016, 4'h0, s);
    checks++; if (s !== 2) begin errors++; $display("FAIL txa_ret_a: got %0d want 2", s); end
  endtask

  task automatic test_flush;
    int s;
    do_reset(1'b0);
    send(16'h0000, 4'h0, s);
    @(negedge clk);
    in_valid = 1'b1; in_opcode = 16'h0004; flush = 1'b1;
    #1;
    checks++; if (in_ready_d !== 1'b1) begin errors++; $display("FAIL flush_ready: got %0b want 1", in_ready_d); end
    @(posedge clk);
    #1;
    checks++; if (out_valid_d !== 1'b0) begin errors++; $display("FAIL flush_bubble: got %0b want 0", out_valid_d); end
    checks++; if (stall_count_d !== 16'd0) begin errors++; $display("FAIL flush_stall_count: got %0d want 0", stall_count_d); end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_freeze_and_reset;
    int s;
    do_reset(1'b0);
    send(16'h0000, 4'h0, s);
    send(16'h0001, 4'h0, s);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_opcode = 16'h0004;
    #1;
    checks++; if (in_ready_d !== 1'b0) begin errors++; $display("FAIL freeze_ready: got %0b want 0", in_ready_d); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checks++; if (out_valid_d !== 1'b1 || out_opcode_d !== 16'h0001 || x_en_d !== 1'b1 || a_en_d !== 1'b0)
        begin errors++; $display("FAIL freeze_out cyc%0d: got valid=%0b op=%h x=%0b a=%0b want 1/0001/1/0", c, out_valid_d, out_opcode_d, x_en_d, a_en_d); end
      checks++; if (stall_count_d !== 16'd0) begin errors++; $display("FAIL freeze_stall cyc%0d: got %0d want 0", c, stall_count_d); end
    end
    send(16'h0004, 4'h0, s);
    checks++; if (s !== 1) begin errors++; $display("FAIL unfreeze_stalls: got %0d want 1", s); end
    checks++; if (stall_count_d !== 16'd1 || out_valid_d !== 1'b1) begin errors++; $display("FAIL unfreeze_state: got stall=%0d valid=%0b want 1/1", stall_count_d, out_valid_d); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid_d !== 1'b0 || stall_count_d !== 16'd0) begin errors++; $display("FAIL async_reset: got valid=%0b stall=%0d want 0/0", out_valid_d, stall_count_d); end
    @(negedge clk);
    rst = 1'b0;
    send(16'h0004, 4'h0, s);
    checks++; if (s !== 0) begin errors++; $display("FAIL post_reset_alu: got %0d want 0", s); end
  endtask

  task automatic test_saturation;
    int s;
    logic [1:0] want;
    do_reset(1'b1);
    send(16'h0000, 4'h0, s);
    for (int n = 1; n <= 4; n++) begin
      send(16'h0004, 4'h0, s);
      want = (n >= 3) ? 2'd3 : 2'(n);
      checks++; if (s !== 1) begin errors++; $display("FAIL sat_stalls n%0d: got %0d want 1", n, s); end
      checks++; if (stall_count_f !== want) begin errors++; $display("FAIL sat_count n%0d: got %0d want %0d", n, stall_count_f, want); end
    end
  endtask

  initial begin
    test_reset();
    test_raw_a();
    test_forwarding();
    test_mem();
    test_tax_txa();
    test_flush();
    test_freeze_and_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bpf_stage1_scoreboard.md
Name: bpf_stage1_scoreboard

Overview:
- Parametrised stage-1 hazard controller for the pipelined BPF CPU.
- Replaces fixed stage2/stage3 A_en/X_en comparisons with an internal scoreboard shift register of in-flight writers of A, X and scratch M[k].
- Provides a valid/ready handshake toward stage 0 and stage 2, an optional writeback bypass (forwarding) mode, branch squash, and a saturating stall-cycle counter.
- Sits between instruction fetch (stage 0) and compute2 (stage 2).

Parameters:
- PIPE_DEPTH, 2: number of downstream stages an instruction occupies before its register write retires; legal range 1..8.
- FWD_EN, 0: 1 = the oldest slot's write is bypassed, so it never causes a stall.
- MEM_TRACK, 1: 1 = track scratch M[k] RAW hazards; 0 = ignore them.
- STALL_CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  opcode valid from stage 0
- in_opcode  in  16  instruction opcode
- in_k_lo  in  4  imm[3:0], the scratch index for LD/LDX/ST/STX MEM
- in_ready  out  1  stage 1 accepts the instruction this cycle
- flush  in  1  taken jump in stage 2: squash the incoming instruction
- out_valid  out  1  registered: out_* fields hold an issued instruction
- out_ready  in  1  stage 2 advances this cycle
- out_opcode  out  16  registered opcode of the issued instruction
- out_A_en  out  1  registered: issued instruction writes A
- out_X_en  out  1  registered: issued instruction writes X
- out_mem_wr  out  1  registered: issued instruction writes M[k]
- stall_count  out  STALL_CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset: all slots invalid; out_valid, out_A_en, out_X_en and out_mem_wr are 0; out_opcode is 0; stall_count is 0. Reset asserted mid-operation discards every in-flight entry immediately.
- Read set of an opcode:
  - A: ALU, JMP, ST, RET A, TAX.
  - X: STX, RET X, TXA, ALU/JMP with opcode[3]=1, LD IND.
  - M[k]: LD MEM, LDX MEM.
- Write set of an opcode:
  - A: LD, ALU, TXA.
  - X: LDX, TAX.
  - M[k]: ST, STX.
- Scoreboard:
  - PIPE_DEPTH slots, each {valid, wA, wX, wM, k[3:0]}.
  - slot[0] is the instruction driving out_*.
  - slot[i] is the instruction in stage i+2.
- hazard (combinational): asserted when, for any valid slot i (excluding i=PIPE_DEPTH-1 when FWD_EN=1), any of these holds:
  - (readA & wA)
  - (readX & wX)
  - (MEM_TRACK & readM & wM & k==in_k_lo)
- in_ready = flush | (out_ready & ~hazard).
- Advance when out_ready=1: slot[i+1] <= slot[i], and slot[PIPE_DEPTH-1] retires. slot[0] is loaded as follows:
  - the new entry if in_valid & ~hazard & ~flush;
  - otherwise a bubble (all zeros).
- When out_ready=0, all slots and out_* hold. flush is still consumed (in_ready=1) and no entry is created.
- Latency: an accepted instruction appears on out_* one cycle after acceptance.
- stall_count increments when in_valid & out_ready & hazard & ~flush. It saturates at all-ones and does not wrap.
- Simultaneous flush and hazard: flush wins. The input is consumed, a bubble is inserted, and the stall is not counted.
- PIPE_DEPTH=1: only slot[0] exists. With FWD_EN=1 no stall is ever generated.

Decomposition:
- Shared package/header (bpf_defs.vh): opcode class codes, addressing-mode codes, RET source codes, and a scoreboard-entry field layout macro.
- Natural sub-module: bpf_rw_set_decode. It is combinational: opcode to {readA, readX, readM, wA, wX, wM}. It is instantiated once for the input; the write bits are stored in the slots.

Test Plan:
- LD #imm (0x0000) accepted, then ALU ADD K (0x0004) next cycle, PIPE_DEPTH=2, FWD_EN=0 -> ALU held with in_ready=0 for 2 cycles, issued on cycle 3; stall_count=2.
- Same sequence with FWD_EN=1 -> 1 stall cycle; stall_count=1.
- ST M[3] (0x0002, k=3) then LDX M[5] (0x0061, k=5) -> no stall. Repeat with LDX M[3] -> 2-cycle stall; with MEM_TRACK=0 -> no stall.
- TAX (0x0007) then RET A (0x0016) -> no stall, since TAX writes X only. TXA (0x0087) then RET A -> stall.
- LD #imm issued, then ALU presented with flush=1 in the same cycle as the hazard -> in_ready=1, out_valid=0 next cycle, stall_count unchanged.
- out_ready=0 held for 3 cycles with the scoreboard full -> out_* and slots frozen. Assert rst mid-run -> out_valid=0 and stall_count=0 asynchronously; the next ALU issues without stall.
